// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR MAC sequencer.
package fir_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  // Slice opmodes: X=M/Z=0 starts a sum, X=M/Z=P accumulates, 0 parks the slice.
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_IDLE  = 8'h00;

  // Index width for n entries; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/tap_shift_reg.sv
// Sample delay line: entry 0 is the newest sample, older samples move toward
// NTAPS-1 on each enabled shift. One random-access read port.
module tap_shift_reg import fir_seq_pkg::*; #(
  parameter int NTAPS = 8,
  parameter int DW    = 18
) (
  input  logic                      clk,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic [DW-1:0]             i_data,
  input  logic [clog2(NTAPS)-1:0]   i_rd_idx,
  output logic [DW-1:0]             o_rd_data
);

  logic [NTAPS-1:0][DW-1:0] r_taps;

  // Shift the new sample in at entry 0; synchronous clear wins.
  always_ff @(posedge clk) begin
    if (i_clr)     r_taps <= '0;
    else if (i_en) r_taps <= {r_taps[NTAPS-2:0], i_data};
  end

  assign o_rd_data = r_taps[i_rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexes one DSP48A1-style slice as an NTAPS-tap FIR engine.
// Optional build macro FIR_SAT_EN: clamp the result to signed SAT_W bits
// and add the sat_flag output.
module fir_mac_sequencer import fir_seq_pkg::*; #(
  parameter int NTAPS   = 8,
  parameter int DW      = 18,
  parameter int PW      = 48,
  parameter int LAT     = 3,
  parameter int OPM_DLY = 1,
  parameter int SAT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DW-1:0]           s_data,
  input  logic                    coef_we,
  input  logic [clog2(NTAPS)-1:0] coef_addr,
  input  logic [DW-1:0]           coef_data,
  output logic [DW-1:0]           dsp_a,
  output logic [DW-1:0]           dsp_b,
  output logic [7:0]              dsp_opmode,
  output logic                    dsp_ce,
  input  logic [PW-1:0]           dsp_p,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [PW-1:0]           m_data,
`ifdef FIR_SAT_EN
  output logic                    sat_flag,
`endif
  output logic                    busy
);

  localparam int AW  = clog2(NTAPS);
  localparam int DCW = clog2(LAT + 1);

  // Elaboration-time parameter sanity.
  if (NTAPS < 2 || LAT < 1 || OPM_DLY < 0 || SAT_W < 2 || SAT_W > PW) begin : g_bad_param
    $error("fir_mac_sequencer: illegal parameter set");
  end

  state_t                   r_state, w_next;
  logic [AW-1:0]            r_k, w_nxt_idx;
  logic [DCW-1:0]           r_dcnt;
  logic [NTAPS-1:0][DW-1:0] r_coef;
  logic [DW-1:0]            r_dsp_a, r_dsp_b, w_a_nxt, w_b_nxt, w_tap_rd;
  logic [OPM_DLY:0][7:0]    r_opm_pipe;
  logic [7:0]               w_opm_nxt;
  logic                     r_ce;
  logic [PW-1:0]            r_m_data, w_cap;
  logic                     w_accept, w_last_tap, w_last_drain, w_coef_wr;

  assign w_accept     = (r_state == IDLE) && s_valid;
  assign w_last_tap   = (r_k == AW'(NTAPS - 1));
  assign w_last_drain = (r_dcnt == DCW'(LAT - 1));
  assign w_coef_wr    = coef_we && (r_state == IDLE || r_state == HOLD);
  assign w_nxt_idx    = r_k + 1'b1;

  tap_shift_reg #(.NTAPS(NTAPS), .DW(DW)) u_taps (
    .clk       (clk),
    .i_clr     (rst),
    .i_en      (w_accept),
    .i_data    (s_data),
    .i_rd_idx  (w_nxt_idx),
    .o_rd_data (w_tap_rd)
  );

`ifdef FIR_SAT_EN
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [PW-1:0] w_p_s;
  logic                 w_hi, w_lo, r_sat;
  assign w_p_s    = dsp_p;
  assign w_hi     = w_p_s > SAT_MAX;
  assign w_lo     = w_p_s < SAT_MIN;
  assign w_cap    = w_hi ? SAT_MAX : (w_lo ? SAT_MIN : dsp_p);
  assign sat_flag = r_sat;

  // Saturation flag travels with the captured result.
  always_ff @(posedge clk) begin
    if (rst)                                r_sat <= 1'b0;
    else if (r_state == DRAIN && w_last_drain) r_sat <= w_hi | w_lo;
  end
`else
  assign w_cap = dsp_p;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (s_valid)      w_next = RUN;
      RUN:   if (w_last_tap)   w_next = DRAIN;
      DRAIN: if (w_last_drain) w_next = HOLD;
      HOLD:  if (m_ready)      w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  // Operands are registered, so load the tap that will be presented next
  // cycle. On accept, tap 0 is the incoming sample and coef 0 is bypassed
  // from a same-cycle write.
  always_comb begin
    w_a_nxt   = '0;
    w_b_nxt   = '0;
    w_opm_nxt = OPM_IDLE;
    if (w_accept) begin
      w_a_nxt   = (coef_we && coef_addr == '0) ? coef_data : r_coef[0];
      w_b_nxt   = s_data;
      w_opm_nxt = OPM_FIRST;
    end else if (r_state == RUN && !w_last_tap) begin
      w_a_nxt   = r_coef[w_nxt_idx];
      w_b_nxt   = w_tap_rd;
      w_opm_nxt = OPM_ACC;
    end
  end

  // Datapath: operand/opmode registers, coefficient file, counters, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dsp_a    <= '0;
      r_dsp_b    <= '0;
      r_opm_pipe <= '0;
      r_ce       <= 1'b0;
      r_coef     <= '0;
      r_k        <= '0;
      r_dcnt     <= '0;
      r_m_data   <= '0;
    end else begin
      r_dsp_a       <= w_a_nxt;
      r_dsp_b       <= w_b_nxt;
      r_ce          <= (w_next == RUN) || (w_next == DRAIN);
      r_opm_pipe[0] <= w_opm_nxt;
      for (int i = 1; i <= OPM_DLY; i++) r_opm_pipe[i] <= r_opm_pipe[i-1];
      if (w_coef_wr) r_coef[coef_addr] <= coef_data;
      if (w_accept)                         r_k <= '0;
      else if (r_state == RUN && !w_last_tap) r_k <= w_nxt_idx;
      r_dcnt <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
      if (r_state == DRAIN && w_last_drain) r_m_data <= w_cap;
    end
  end

  assign dsp_a      = r_dsp_a;
  assign dsp_b      = r_dsp_b;
  assign dsp_opmode = r_opm_pipe[OPM_DLY];
  assign dsp_ce     = r_ce;
  assign m_data     = r_m_data;
  assign m_valid    = (r_state == HOLD);
  assign s_ready    = (r_state == IDLE);
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural slice model.
module tb_fir_mac_sequencer;
  localparam int NT = 4, DW = 18, PW = 48, LAT = 3, OPM_DLY = 1;
`ifdef FIR_SAT_EN
  localparam int SATW = 8;
`else
  localparam int SATW = 32;
`endif

  logic          clk, rst, s_valid, s_ready, coef_we, dsp_ce, m_valid, m_ready, busy;
  logic [DW-1:0] s_data, coef_data, dsp_a, dsp_b;
  logic [1:0]    coef_addr;
  logic [7:0]    dsp_opmode;
  logic [PW-1:0] dsp_p, m_data;
`ifdef FIR_SAT_EN
  logic          sat_flag;
`endif

  fir_mac_sequencer #(.NTAPS(NT), .DW(DW), .PW(PW), .LAT(LAT), .OPM_DLY(OPM_DLY), .SAT_W(SATW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_p(dsp_p),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef FIR_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: A1/B1 -> M -> P, opmode register, common CE.
  logic signed [DW-1:0] a1, b1;
  logic signed [PW-1:0] mreg, preg;
  logic [7:0]           opr;
  always @(posedge clk) begin
    if (rst) begin
      a1 <= '0; b1 <= '0; mreg <= '0; preg <= '0; opr <= '0;
    end else if (dsp_ce) begin
      a1   <= dsp_a;
      b1   <= dsp_b;
      mreg <= a1 * b1;
      opr  <= dsp_opmode;
      preg <= ((opr[1:0] == 2'b01) ? mreg : 48'sd0) + (opr[3] ? preg : 48'sd0);
    end
  end
  assign dsp_p = preg;

  int checks = 0, fails = 0, cyc = 0;

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wcoef(input logic [1:0] a, input logic [DW-1:0] v);
    coef_we = 1'b1; coef_addr = a; coef_data = v;
    tick();
    coef_we = 1'b0;
  endtask

  // Offer a sample and return the cycle index at which it was accepted.
  task automatic send(input logic [DW-1:0] d, output int acc);
    int w;
    w = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && w < 40) begin tick(); w++; end
    chk("s_ready_before_accept", s_ready, 1);
    acc = cyc;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_res(input int acc, input logic [PW-1:0] exp, input string tag);
    while (!m_valid && (cyc - acc) < 40) tick();
    chk({tag, "_latency"}, cyc - acc, NT + LAT + 1);
    chk(tag, m_data, exp);
  endtask

  logic [7:0]    exp_opm [1:8];
  logic [DW-1:0] exp_a   [1:8];
  int acc, acc_prev, ce_cnt;

  initial begin
    exp_opm = '{8'h00, 8'h01, 8'h09, 8'h09, 8'h09, 8'h00, 8'h00, 8'h00};
    exp_a   = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd0, 18'd0, 18'd0, 18'd0};
    rst = 1'b1; s_valid = 1'b0; s_data = '0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_dsp_b", dsp_b, 0);
    chk("rst_opmode", dsp_opmode, 0);
    chk("rst_ce", dsp_ce, 0);
    chk("rst_busy", busy, 0);
    ce_cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); ce_cnt += int'(dsp_ce); end
    chk("idle_ce_pulses", ce_cnt, 0);
    chk("idle_busy", busy, 0);

    // Coefficients {1,2,3,4}.
    for (int i = 0; i < NT; i++) wcoef(2'(i), DW'(i + 1));
    m_ready = 1'b1;

    // Sample 1 with cycle-by-cycle operand/opmode trace.
    send(18'd1, acc);
    for (int n = 1; n <= 8; n++) begin
      chk($sformatf("trace_opm_%0d", n), dsp_opmode, exp_opm[n]);
      chk($sformatf("trace_a_%0d", n), dsp_a, exp_a[n]);
      chk($sformatf("trace_b_%0d", n), dsp_b, (n == 1) ? 1 : 0);
      chk($sformatf("trace_ce_%0d", n), dsp_ce, (n <= 7) ? 1 : 0);
      chk($sformatf("trace_mvalid_%0d", n), m_valid, (n == 8) ? 1 : 0);
      if (n < 8) tick();
    end
    chk("res1", m_data, 1);
    tick();
    chk("res1_release_mvalid", m_valid, 0);
    chk("res1_release_ready", s_ready, 1);

    // Samples 2 and 3, back-to-back throughput.
    send(18'd2, acc); acc_prev = acc;
    wait_res(acc, 4, "res2"); tick();
    send(18'd3, acc);
    chk("throughput", acc - acc_prev, NT + LAT + 2);
    wait_res(acc, 10, "res3"); tick();

    // Back-pressure: hold result, offer a sample that must wait.
    m_ready = 1'b0;
    send(18'd4, acc);
    wait_res(acc, 20, "res4");
    s_valid = 1'b1; s_data = 18'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_mvalid", m_valid, 1);
      chk("hold_mdata", m_data, 20);
      chk("hold_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    tick();
    chk("release_mvalid", m_valid, 0);
    chk("release_idle_ready", s_ready, 1);
    chk("release_idle_busy", busy, 0);
    acc = cyc;
    tick();
    s_valid = 1'b0;
    chk("pending_accepted", busy, 1);
    wait_res(acc, 34, "res9"); tick();

    // Coefficient write during RUN is ignored.
    send(18'd5, acc);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 18'd7;
    tick();
    coef_we = 1'b0;
    wait_res(acc, 47, "run_wr_cur"); tick();
    send(18'd6, acc);
    wait_res(acc, 59, "run_wr_next"); tick();

    // Coefficient write in IDLE alongside the accept applies immediately.
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 18'd7;
    send(18'd1, acc);
    coef_we = 1'b0;
    wait_res(acc, 70, "idle_wr"); tick();

    // Reset mid-computation aborts and clears coefficients and taps.
    send(18'd3, acc);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_mvalid", m_valid, 0);
    chk("abort_ce", dsp_ce, 0);
    chk("abort_dsp_a", dsp_a, 0);
    send(18'd5, acc);
    wait_res(acc, 0, "coef_cleared"); tick();
    rst = 1'b1; tick(); rst = 1'b0;

`ifdef FIR_SAT_EN
    wcoef(2'd0, 18'd100); wcoef(2'd1, 18'd100);
    send(18'd1, acc);
    wait_res(acc, 100, "sat_res1");
    chk("sat_flag1", sat_flag, 0);
    tick();
    send(18'd2, acc);
    wait_res(acc, 127, "sat_res2");
    chk("sat_flag2", sat_flag, 1);
    tick();
`else
    for (int i = 0; i < NT; i++) wcoef(2'(i), DW'(i + 1));
    send(18'd2, acc);
    wait_res(acc, 2, "taps_cleared"); tick();
    send(18'd1, acc);
    wait_res(acc, 5, "after_clear"); tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Upstream controller for the DSP48A1-style slice; time-multiplexes one slice as an N-tap FIR / dot-product engine.
- Accepts samples on a valid/ready stream and holds them in an N-deep delay line next to an N-entry coefficient file.
- Drives the slice operands and opmode one tap per cycle, then captures the slice `p` result into a registered, back-pressured output stream.

Parameters:
- NTAPS, 8: number of taps / coefficients, ≥2.
- DW, 18: operand width; matches the slice A/B width.
- PW, 48: accumulator / `p` width.
- LAT, 3: cycles from operands presented on dsp_a/dsp_b to the corresponding `p` being valid. A1/B1 reg + MREG + PREG gives 3.
- OPM_DLY, 1: cycles dsp_opmode lags the operands it applies to. Compensates the slice OPMODEREG.
- SAT_W, 32: signed clamp width, used only with FIR_SAT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  sequencer can accept a sample
- s_data  in  DW  input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  coefficient index
- coef_data  in  DW  coefficient value
- dsp_a  out  DW  to slice `a` (coefficient)
- dsp_b  out  DW  to slice `b` (delayed sample)
- dsp_opmode  out  8  to slice `opmode`
- dsp_ce  out  1  common clock enable for slice A/B/M/P/opmode registers
- dsp_p  in  PW  from slice `p`
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  PW  FIR result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge) produces:
  - state IDLE, s_ready=1, m_valid=0, m_data=0, dsp_a=0, dsp_b=0, dsp_opmode=0, dsp_ce=0, busy=0;
  - delay line and tap counter cleared;
  - coefficient file cleared to 0.
- Reset mid-operation aborts the computation; the partial result is discarded.
- States:
  - IDLE: s_ready=1. On s_valid, shift s_data into delay line entry 0 (older samples move toward NTAPS-1), clear k, go to RUN.
  - RUN: one tap per cycle; dsp_a=coef[k], dsp_b=tap[k], dsp_ce=1. After k=NTAPS-1 go to DRAIN, otherwise k++.
  - DRAIN: dsp_ce=1, dsp_a=dsp_b=0, for LAT cycles. On the final cycle, capture dsp_p (or its clamp) into m_data, set m_valid, go to HOLD.
  - HOLD: m_valid=1 with m_data stable until m_ready=1, then m_valid=0 and go to IDLE. The idle cycle is mandatory; there is no pass-through to RUN.
- Opmode for tap k is issued exactly OPM_DLY cycles after that tap's operands:
  - k=0: 8'h01 (X=M, Z=0, add, no preadder, carry 0).
  - k≥1: 8'h09 (X=M, Z=P).
  - All other cycles: 8'h00.
- dsp_a, dsp_b and dsp_opmode are driven from registers.
- Latency: sample accepted at cycle c0 → m_valid at c0+NTAPS+LAT+1.
- Throughput: one result per NTAPS+LAT+2 cycles when m_ready is held high.
- s_ready is 0 outside IDLE; samples offered then are not consumed.
- Coefficient writes:
  - Accepted only in IDLE or HOLD; ignored in RUN/DRAIN.
  - A write in IDLE on the same cycle as a sample accept takes effect for that sample's computation.
- Arithmetic: pass-through only; signedness is the slice's. The sequencer performs no sign extension except under FIR_SAT_EN.
- m_ready while m_valid=0 has no effect.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: the captured value is clamped to the signed SAT_W range [-2^(SAT_W-1), 2^(SAT_W-1)-1], then sign-extended to PW. Port sat_flag (out, 1) is added; it is registered with m_data and set when clamping occurred.
- Undefined: dsp_p is captured unchanged and there is no sat_flag port.

Decomposition:
- Package fir_seq_pkg:
  - state enum {IDLE, RUN, DRAIN, HOLD};
  - constants OPM_FIRST=8'h01, OPM_ACC=8'h09, OPM_IDLE=8'h00;
  - function clog2.
- Sub-module tap_shift_reg (parameters NTAPS, DW): enable-shift delay line with synchronous clear and per-index read.

Test Plan:
- Reset then idle → all outputs 0, s_ready=1, no dsp_ce pulses.
- NTAPS=4, LAT=3, coefs {1,2,3,4}; samples 1, 2, 3 with m_ready=1 → m_data 1, 4, 10. Each m_valid arrives 8 cycles after its accept.
- Opmode trace for one sample → 8'h01 one cycle after tap-0 operands, then 8'h09 ×3, else 8'h00.
- m_ready held 0 for 5 cycles in HOLD → m_data stable, s_ready=0, a second offered sample is not consumed until the release and one IDLE cycle.
- coef_we to addr 0 (value 7) during RUN → ignored for the current and next results. The same write in IDLE → next result uses 7.
- FIR_SAT_EN, SAT_W=8, coefs {100,100,0,0}, samples 1 then 2 → second result 300 clamps to 127 with sat_flag=1; the first result (100) has sat_flag=0.
